ds_interp_feeder: RTL
=====================

// Module: ds_interp_feeder
// PURPOSE
//  Upstream feeder for the 1st-order delta-sigma DAC. Accepts 16-bit signed PCM samples at the
//  base rate over a valid/ready stream and buffers them in a small FIFO. Linearly interpolates
//  by 2^OSR_LOG2 and drives the modulator's data input together with its clock-enable tick.
//  It owns the oversampling timebase: one cke every CKE_DIV clk, one input sample per 2^OSR_LOG2 cke.
// PARAMETERS
//  CKE_DIV     4   clk cycles per modulator tick (>=1; 1 => cke held high)
//  OSR_LOG2    6   log2 of interpolation ratio (1..10); ticks per input sample = 2^OSR_LOG2
//  FIFO_DEPTH  4   input FIFO entries (power of 2, >=2)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   synchronous reset, active low
//  s_data        in   16  signed PCM input sample
//  s_valid       in   1   s_data valid
//  s_ready       out  1   FIFO not full; transfer when s_valid && s_ready
//  cke           out  1   modulator clock enable, 1-clk pulse every CKE_DIV clk
//  dout_data     out  16  signed interpolated sample to modulator din
//  underrun      out  1   sticky: FIFO was empty at a sample boundary while running
//  underrun_clr  in   1   clears underrun (set wins if same cycle)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): cke=0, dout_data=0, underrun=0, s_ready=0, FIFO empty, prescaler=0,
//   phase=0, state=IDLE. s_ready goes 1 on the first cycle after reset release.
//  Prescaler: counts 0..CKE_DIV-1. "tick" is the edge where it wraps. cke is registered =1 for the
//   clk cycle after each tick. dout_data updates only on tick edges, so it is stable while cke=1.
//   cke free-runs in all states.
//  Phase counter: OSR_LOG2 bits, increments per tick, wraps at 2^OSR_LOG2. Wrap = sample boundary.
//  Interpolator registers:
//   cur = target sample (16b)
//   diff = cur - prev (17b signed)
//   acc = 16+OSR_LOG2 bits signed
//   dout_data = acc >>> OSR_LOG2 (arithmetic; no rounding)
//  FSM:
//   IDLE: acc=0, dout_data=0. On a tick with FIFO non-empty: pop -> cur, prev=0,
//     diff=cur, acc=0, phase=0 -> RUN. Tick with FIFO empty: stay IDLE, no underrun.
//   RUN, non-boundary tick: acc += diff; phase++.
//   RUN, boundary tick (phase == 2^OSR_LOG2-1):
//     acc reloaded to cur<<<OSR_LOG2 (exact endpoint, no drift), prev=cur.
//     If FIFO non-empty: pop -> cur, diff = new - old cur.
//     If FIFO empty: diff=0, cur unchanged (hold last value), underrun=1. Remains in RUN and
//     resumes interpolation from the held value at the next successful pop.
//   No return to IDLE except via reset.
//  Values always lie between prev and cur. No saturation needed: |diff| <= 65535 fits 17b, and
//   acc never leaves [min(prev,cur), max(prev,cur)] << OSR_LOG2.
//  Latency: a sample accepted into an empty FIFO in IDLE reaches dout_data exactly at the end of
//   its ramp, 2^OSR_LOG2 ticks after the pop tick.
//  FIFO:
//   - Push and pop in the same cycle are both honoured.
//   - Full => s_ready=0. A push into a full FIFO cannot occur.
//   - Pop only happens on ticks.
//  Reset mid-stream: FIFO flushed, outputs to reset values next cycle, regardless of state.
//  underrun_clr and a new underrun on the same edge => underrun=1.
// STRUCTURE
//  ds_pkg: typedef logic signed [15:0] sample_t. Also holds interp_state_e {IDLE,RUN}.
//  Sub-module sync_fifo: parameterised width/depth; full/empty flags; registered output;
//   synchronous active-low reset. Prescaler, phase counter, FSM and interpolator live in the top.
// TESTING
//  1 Reset: hold rst_n=0 5 clk -> cke=0, dout_data=0, s_ready=0; release -> s_ready=1 next clk,
//    cke period = CKE_DIV.
//  2 Ramp: OSR_LOG2=2, push 400 then 400 -> dout_data per tick 0,100,200,300, then 400 held.
//  3 Step down: prev=1000, push -1000 (OSR_LOG2=2) -> 1000,500,0,-500,-1000. Check the
//    arithmetic shift on negatives.
//  4 Extremes: push -32768 then 32767 (OSR_LOG2=6) -> monotonic ramp, endpoints exact,
//    no overflow of diff or acc.
//  5 Underrun: stop feeding after 3 samples -> last sample held, underrun=1. underrun_clr -> 0.
//    Resume -> ramps from the held value.
//  6 Backpressure: burst 8 samples with FIFO_DEPTH=4 -> s_ready drops after 4. No sample lost or
//    duplicated (scoreboard vs. golden interpolation). Mid-stream rst_n pulse -> IDLE, output 0.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared types for the delta-sigma DAC front end: PCM sample type and
// interpolator state encoding.
package ds_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    RUN
  } interp_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head word: rd_data always shows the
// oldest entry while empty is low, so a pop and its data share one edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [AW:0]      remaining;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_wr;
  logic             do_rd;

  assign full        = (count_reg == FULL_CNT);
  assign empty       = (count_reg == '0);
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign rd_ptr_next = rd_ptr_reg + AW'(do_rd);
  assign remaining   = count_reg - (AW+1)'(do_rd);
  assign count_next  = remaining + (AW+1)'(do_wr);
  assign rd_data     = rd_data_reg;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // New head: the incoming word when nothing older survives this edge.
      if (do_wr || do_rd) begin
        rd_data_reg <= (remaining == '0) ? wr_data : mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/ds_interp_feeder.sv
// Delta-sigma modulator feeder: buffers base-rate PCM, owns the cke timebase and
// linearly interpolates each sample over 2^OSR_LOG2 modulator ticks.
module ds_interp_feeder
  import ds_pkg::*;
#(
  parameter int CKE_DIV    = 4,
  parameter int OSR_LOG2   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [15:0]  s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                cke,
  output logic signed [15:0]  dout_data,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam int PW = (CKE_DIV > 1) ? $clog2(CKE_DIV) : 1;
  localparam int AW = SAMPLE_W + OSR_LOG2;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CKE_DIV - 1);

  logic [PW-1:0]          presc_reg;
  logic [OSR_LOG2-1:0]    phase_reg;
  logic                   cke_reg;
  logic                   underrun_reg;
  logic                   ready_en_reg;
  interp_state_e          state_reg;
  sample_t                cur_reg;
  logic signed [16:0]     diff_reg;
  logic signed [AW-1:0]   acc_reg;

  sample_t                head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   tick;
  logic                   boundary;
  logic                   push;
  logic                   pop;

  assign tick     = (presc_reg == PRESC_MAX);
  assign boundary = &phase_reg;
  assign s_ready  = ready_en_reg && !fifo_full;
  assign push     = s_valid && s_ready;
  assign pop      = tick && !fifo_empty && ((state_reg == IDLE) || boundary);

  assign cke       = cke_reg;
  assign underrun  = underrun_reg;
  assign dout_data = acc_reg[AW-1:OSR_LOG2];

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      phase_reg    <= '0;
      cke_reg      <= 1'b0;
      underrun_reg <= 1'b0;
      ready_en_reg <= 1'b0;
      state_reg    <= IDLE;
      cur_reg      <= '0;
      diff_reg     <= '0;
      acc_reg      <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      cke_reg      <= tick;
      presc_reg    <= tick ? '0 : presc_reg + PW'(1);
      if (underrun_clr) begin
        underrun_reg <= 1'b0;
      end
      if (tick) begin
        case (state_reg)
          IDLE: begin
            // First sample ramps up from zero.
            if (!fifo_empty) begin
              cur_reg   <= head;
              diff_reg  <= 17'(head);
              acc_reg   <= '0;
              phase_reg <= '0;
              state_reg <= RUN;
            end
          end
          RUN: begin
            phase_reg <= phase_reg + OSR_LOG2'(1);
            if (boundary) begin
              // Snap to the exact endpoint so rounding never accumulates.
              acc_reg <= {cur_reg, {OSR_LOG2{1'b0}}};
              if (!fifo_empty) begin
                cur_reg  <= head;
                diff_reg <= 17'(head) - 17'(cur_reg);
              end else begin
                diff_reg     <= '0;
                underrun_reg <= 1'b1;
              end
            end else begin
              acc_reg <= acc_reg + AW'(diff_reg);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
